seq_addsub: RTL and testbench

Multi-cycle, parametrised add / subtract / absolute-difference unit for unsigned operands. It processes operands DIGIT_BITS bits per cycle, least-significant digit first, so wide Karatsuba operands can be handled without a full-width carry/borrow chain. It sits between the operand-split stage and the recursive multiplier stage, producing |a_hi − a_lo| with a sign flag, plus plain sums and differences. Valid/ready handshakes on input and output; one operation in flight.

---
 rtl/seq_addsub.sv | 150 +++++++++++++++
 tb/tb_seq_addsub.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial add / sub / |a-b| unit for unsigned operands.
// One DIGIT_BITS slice per cycle, LSD first; a-b and b-a borrow chains run together.
module seq_addsub #(
    parameter int N_BITS     = 16,
    parameter int DIGIT_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS:0]   result,
    output logic              neg
);
    localparam int DW         = (DIGIT_BITS > 0) ? DIGIT_BITS : 1;
    localparam int DW1        = DW + 1;
    localparam int NUM_DIGITS = N_BITS / DW;
    localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (DIGIT_BITS <= 0 || (N_BITS % DW) != 0) begin : g_bad_cfg
        $error("seq_addsub: DIGIT_BITS must be nonzero and divide N_BITS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [N_BITS-1:0] ra, rb;
    logic [1:0]        rop;
    logic [CW-1:0]     cnt;
    logic              cy, bab, bba;
    logic [N_BITS-1:0] sum_sh, dab_sh, dba_sh;

    logic [DW-1:0]     da, db;
    logic [DW:0]       s_d, ab_d, ba_d;
    logic [N_BITS-1:0] sum_nx, dab_nx, dba_nx;
    logic              last;
    logic [N_BITS:0]   res_nx;
    logic              neg_nx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (in_valid)  state_nx = S_RUN;
            S_RUN:   if (last)      state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decode from the state register only
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // One digit of the sum and both differences, merged into the shift registers
    always_comb begin
        da     = ra[DW-1:0];
        db     = rb[DW-1:0];
        s_d    = {1'b0, da} + {1'b0, db} + DW1'(cy);
        ab_d   = {1'b0, da} - {1'b0, db} - DW1'(bab);
        ba_d   = {1'b0, db} - {1'b0, da} - DW1'(bba);
        sum_nx = (sum_sh >> DIGIT_BITS)
               | (N_BITS'(s_d[DW-1:0]) << (N_BITS - DIGIT_BITS));
        dab_nx = (dab_sh >> DIGIT_BITS)
               | (N_BITS'(ab_d[DW-1:0]) << (N_BITS - DIGIT_BITS));
        dba_nx = (dba_sh >> DIGIT_BITS)
               | (N_BITS'(ba_d[DW-1:0]) << (N_BITS - DIGIT_BITS));
        last   = (cnt == CW'(NUM_DIGITS - 1));
    end

    // Final result select; the a-b borrow out picks the b-a chain for ABSDIFF
    always_comb begin
        res_nx = {s_d[DW], sum_nx};
        neg_nx = 1'b0;
        unique case (rop)
            2'b00: begin
                res_nx = {s_d[DW], sum_nx};
                neg_nx = 1'b0;
            end
            2'b10: begin
                res_nx = ab_d[DW] ? {1'b0, dba_nx} : {1'b0, dab_nx};
                neg_nx = ab_d[DW];
            end
            default: begin
                res_nx = {ab_d[DW], dab_nx};
                neg_nx = ab_d[DW];
            end
        endcase
    end

    // Operand capture, digit stepping and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            rop    <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            bab    <= 1'b0;
            bba    <= 1'b0;
            sum_sh <= '0;
            dab_sh <= '0;
            dba_sh <= '0;
            result <= '0;
            neg    <= 1'b0;
        end else if (state == S_IDLE) begin
            if (in_valid) begin
                ra  <= a;
                rb  <= b;
                rop <= op;
                cnt <= '0;
                cy  <= 1'b0;
                bab <= 1'b0;
                bba <= 1'b0;
            end
        end else if (state == S_RUN) begin
            ra     <= ra >> DIGIT_BITS;
            rb     <= rb >> DIGIT_BITS;
            cy     <= s_d[DW];
            bab    <= ab_d[DW];
            bba    <= ba_d[DW];
            sum_sh <= sum_nx;
            dab_sh <= dab_nx;
            dba_sh <= dba_nx;
            cnt    <= cnt + CW'(1);
            if (last) begin
                result <= res_nx;
                neg    <= neg_nx;
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: scoreboard bench for seq_addsub at DIGIT_BITS 1, 4 and 16.
// Lane 1 (DIGIT_BITS=4) carries the directed cases; all lanes get random ops.
module tb_seq_addsub;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic          neg       [3];
    logic [NB-1:0] a_s       [3];
    logic [NB-1:0] b_s       [3];
    logic [1:0]    op_s      [3];
    logic [NB:0]   result    [3];

    logic [NB+1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_addsub #(
            .N_BITS    (NB),
            .DIGIT_BITS((g == 0) ? 1 : ((g == 1) ? 4 : 16))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a_s[g]),
            .b        (b_s[g]),
            .op       (op_s[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .result   (result[g]),
            .neg      (neg[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic int dbits(input int l);
        return (l == 0) ? 1 : ((l == 1) ? 4 : 16);
    endfunction

    // Behavioural reference: {neg, result}
    function automatic logic [NB+1:0] model(input logic [1:0] o,
                                            input logic [NB-1:0] x,
                                            input logic [NB-1:0] y);
        logic [NB:0] r;
        logic        n;
        n = (x < y);
        case (o)
            2'b00:   begin r = {1'b0, x} + {1'b0, y}; n = 1'b0; end
            2'b10:   r = n ? {1'b0, y - x} : {1'b0, x - y};
            default: r = {1'b0, x} - {1'b0, y};
        endcase
        return {n, r};
    endfunction

    // Scoreboard: pop and compare on every output handshake
    always @(negedge clk) begin
        logic [NB+1:0] e;
        for (int l = 0; l < 3; l++) begin
            if (rst_n && out_valid[l] && out_ready[l]) begin
                if (exp_q.size() == 0) begin
                    check("sb_depth", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result[l], e[NB:0]);
                    check("neg", neg[l], e[NB+1]);
                end
            end
        end
    end

    // Present an op at the next negedge; returns just after the acceptance edge
    task automatic issue(input int l, input logic [1:0] o,
                         input logic [NB-1:0] x, input logic [NB-1:0] y);
        @(negedge clk);
        check("in_ready_idle", in_ready[l], 1);
        op_s[l]     = o;
        a_s[l]      = x;
        b_s[l]      = y;
        in_valid[l] = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(o, x, y));
        #1 in_valid[l] = 1'b0;
    endtask

    // Wait for the result, optionally stall, then complete the handshake
    task automatic collect(input int l, input int hold);
        int            lat;
        logic          ov;
        logic [NB:0]   r;
        logic          ng;
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            ov = out_valid[l];
        end
        check("latency", lat, NB / dbits(l));
        r  = result[l];
        ng = neg[l];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid[l], 1);
            check("hold_ready", in_ready[l], 0);
            check("hold_res", result[l], r);
            check("hold_neg", neg[l], ng);
        end
        out_ready[l] = 1'b1;
        @(posedge clk);
        #1 out_ready[l] = 1'b0;
        check("post_ready", in_ready[l], 1);
        check("post_valid", out_valid[l], 0);
    endtask

    task automatic run_op(input int l, input logic [1:0] o,
                          input logic [NB-1:0] x, input logic [NB-1:0] y,
                          input int hold);
        issue(l, o, x, y);
        collect(l, hold);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB:0]   r;
        logic          ng;
        logic [1:0]    o;
        logic [NB-1:0] x, y;
        rst_n = 1'b0;
        for (int l = 0; l < 3; l++) begin
            in_valid[l]  = 1'b0;
            out_ready[l] = 1'b0;
            a_s[l]       = '0;
            b_s[l]       = '0;
            op_s[l]      = '0;
        end
        #3;
        for (int l = 0; l < 3; l++) begin
            check("rst_valid", out_valid[l], 0);
            check("rst_ready", in_ready[l], 1);
            check("rst_result", result[l], 0);
            check("rst_neg", neg[l], 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(1, 2'b01, 16'h0005, 16'h0003, 0);
        run_op(1, 2'b01, 16'h0003, 16'h0005, 0);
        run_op(1, 2'b10, 16'h0003, 16'h0005, 0);
        run_op(1, 2'b10, 16'h1234, 16'h1234, 0);
        run_op(1, 2'b00, 16'hFFFF, 16'h0001, 0);
        run_op(1, 2'b11, 16'h0010, 16'h0001, 0);
        run_op(1, 2'b10, 16'h0000, 16'hFFFF, 0);
        run_op(1, 2'b01, 16'h0000, 16'h0000, 0);

        // Backpressure with a new op waiting during DONE
        issue(1, 2'b01, 16'h00AA, 16'h0055);
        repeat (4) @(posedge clk);
        #1;
        check("bp_valid", out_valid[1], 1);
        r           = result[1];
        ng          = neg[1];
        op_s[1]     = 2'b00;
        a_s[1]      = 16'h1111;
        b_s[1]      = 16'h2222;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid[1], 1);
            check("bp_hold_ready", in_ready[1], 0);
            check("bp_hold_res", result[1], r);
            check("bp_hold_neg", neg[1], ng);
        end
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1 out_ready[1] = 1'b0;
        check("bp_idle_ready", in_ready[1], 1);
        @(posedge clk);
        exp_q.push_back(model(2'b00, 16'h1111, 16'h2222));
        #1 in_valid[1] = 1'b0;
        check("bp_accepted", in_ready[1], 0);
        collect(1, 0);

        // Reset during RUN at digit 2
        issue(1, 2'b01, 16'h0000, 16'h0001);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", out_valid[1], 0);
        check("mid_rst_ready", in_ready[1], 1);
        check("mid_rst_result", result[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 2'b00, 16'h0001, 16'h0001, 0);

        // Random sweep on all three digit widths
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 1000; i++) begin
                o = 2'($urandom_range(0, 3));
                x = 16'($urandom);
                y = 16'($urandom);
                case ($urandom_range(0, 7))
                    0:       y = x;
                    1:       x = 16'hFFFF;
                    2:       y = 16'hFFFF;
                    3:       x = 16'h0000;
                    default: ;
                endcase
                run_op(l, o, x, y, $urandom_range(0, 2));
            end
        end

        repeat (2) @(negedge clk);
        check("sb_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
